// File: rtl/seg_argmax_head.sv
`default_nettype none
// ============================================================================
// Module   : seg_argmax_head
// Purpose  : Pipelined per-pixel argmax over CNN feature units, with uint8
//            confidence and a per-frame label histogram bank.
// Revision : 1.0 - initial release
// ============================================================================
module seg_argmax_head #(
  parameter int HEIGHT    = -1,
  parameter int WIDTH     = -1,
  parameter int W_HEIGHT  = -1,
  parameter int W_WIDTH   = -1,
  parameter int UINT_BITW = 8,
  parameter int UNITS     = 12,
  parameter int INT_BITW  = 5,
  parameter int FRAC_BITW = 8,
  localparam int V_BITW   = $clog2(W_HEIGHT),
  localparam int H_BITW   = $clog2(W_WIDTH),
  localparam int LBL_BITW = $clog2(UNITS),
  localparam int FX_BITW  = INT_BITW + FRAC_BITW,
  localparam int CNT_BITW = $clog2(HEIGHT * WIDTH + 1)
) (
  input  logic                       clock,
  input  logic                       n_rst,
  input  logic [0:FX_BITW*UNITS-1]   in_feat,
  input  logic [V_BITW-1:0]          in_vcnt,
  input  logic [H_BITW-1:0]          in_hcnt,
  output logic [LBL_BITW-1:0]        out_label,
  output logic [UINT_BITW-1:0]       out_conf,
  output logic [V_BITW-1:0]          out_vcnt,
  output logic [H_BITW-1:0]          out_hcnt,
  output logic                       frame_done,
  input  logic [LBL_BITW-1:0]        hist_sel,
  output logic [CNT_BITW-1:0]        hist_count
);

  localparam int NSTG = LBL_BITW;

  function automatic int stg_cnt(input int s);
    int n;
    n = UNITS;
    for (int i = 0; i < s; i++) n = (n + 1) / 2;
    return n;
  endfunction

  // Level 0 is the raw input; level s is the registered output of tree stage s.
  logic signed [FX_BITW-1:0] w_lvl_val [0:NSTG][UNITS];
  logic [LBL_BITW-1:0]       w_lvl_idx [0:NSTG][UNITS];
  logic signed [FX_BITW-1:0] r_val     [1:NSTG][UNITS];
  logic [LBL_BITW-1:0]       r_idx     [1:NSTG][UNITS];

  always_comb begin
    for (int j = 0; j < UNITS; j++) begin
      w_lvl_val[0][j] = in_feat[j*FX_BITW +: FX_BITW];
      w_lvl_idx[0][j] = LBL_BITW'(j);
      for (int s = 1; s <= NSTG; s++) begin
        w_lvl_val[s][j] = r_val[s][j];
        w_lvl_idx[s][j] = r_idx[s][j];
      end
    end
  end

  generate
    for (genvar s = 1; s <= NSTG; s++) begin : g_stage
      for (genvar j = 0; j < UNITS; j++) begin : g_node
        if (2*j + 1 < stg_cnt(s-1)) begin : g_pair
          logic w_take_hi;
          // Higher index must be strictly greater, so ties keep the lower index.
          assign w_take_hi = w_lvl_val[s-1][2*j+1] > w_lvl_val[s-1][2*j];
          always_ff @(posedge clock or negedge n_rst) begin
            if (!n_rst) begin
              r_val[s][j] <= '0;
              r_idx[s][j] <= '0;
            end else if (w_take_hi) begin
              r_val[s][j] <= w_lvl_val[s-1][2*j+1];
              r_idx[s][j] <= w_lvl_idx[s-1][2*j+1];
            end else begin
              r_val[s][j] <= w_lvl_val[s-1][2*j];
              r_idx[s][j] <= w_lvl_idx[s-1][2*j];
            end
          end
        end else if (2*j < stg_cnt(s-1)) begin : g_pass
          always_ff @(posedge clock or negedge n_rst) begin
            if (!n_rst) begin
              r_val[s][j] <= '0;
              r_idx[s][j] <= '0;
            end else begin
              r_val[s][j] <= w_lvl_val[s-1][2*j];
              r_idx[s][j] <= w_lvl_idx[s-1][2*j];
            end
          end
        end else begin : g_idle
          always_ff @(posedge clock or negedge n_rst) begin
            if (!n_rst) begin
              r_val[s][j] <= '0;
              r_idx[s][j] <= '0;
            end else begin
              r_val[s][j] <= '0;
              r_idx[s][j] <= '0;
            end
          end
        end
      end
    end
  endgenerate

  logic signed [FX_BITW-1:0] w_win_val;
  logic [UINT_BITW-1:0]      w_conf;

  assign w_win_val = w_lvl_val[NSTG][0];

  always_comb begin
    w_conf = w_win_val[FRAC_BITW-1:0];
    if (w_win_val[FX_BITW-1])
      w_conf = '0;
    else if (|w_win_val[FX_BITW-2:FRAC_BITW])
      w_conf = '1;
  end

  // r_live marks pipeline slots filled since reset so flushed zeros never count.
  logic [V_BITW-1:0] r_vdly [NSTG];
  logic [H_BITW-1:0] r_hdly [NSTG];
  logic [NSTG:0]     r_live;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < NSTG; k++) begin
        r_vdly[k] <= '0;
        r_hdly[k] <= '0;
      end
      r_live    <= '0;
      out_label <= '0;
      out_conf  <= '0;
      out_vcnt  <= '0;
      out_hcnt  <= '0;
    end else begin
      r_vdly[0] <= in_vcnt;
      r_hdly[0] <= in_hcnt;
      for (int k = 1; k < NSTG; k++) begin
        r_vdly[k] <= r_vdly[k-1];
        r_hdly[k] <= r_hdly[k-1];
      end
      r_live    <= {r_live[NSTG-1:0], 1'b1};
      out_label <= w_lvl_idx[NSTG][0];
      out_conf  <= w_conf;
      out_vcnt  <= r_vdly[NSTG-1];
      out_hcnt  <= r_hdly[NSTG-1];
    end
  end

  logic                w_active;
  logic                w_frame_end;
  logic [CNT_BITW-1:0] r_cnt  [UNITS];
  logic [CNT_BITW-1:0] r_bank [UNITS];
  logic [CNT_BITW-1:0] w_next [UNITS];

  assign w_active    = r_live[NSTG] && (int'(out_vcnt) < HEIGHT) && (int'(out_hcnt) < WIDTH);
  assign w_frame_end = r_live[NSTG] && (out_vcnt == V_BITW'(W_HEIGHT - 1))
                                    && (out_hcnt == H_BITW'(W_WIDTH - 1));

  always_comb begin
    for (int k = 0; k < UNITS; k++) begin
      w_next[k] = r_cnt[k];
      if (w_active && (out_label == LBL_BITW'(k)) && (r_cnt[k] != '1))
        w_next[k] = r_cnt[k] + 1'b1;
    end
  end

  // The frame-end snapshot takes w_next so the final pixel lands in this bank.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < UNITS; k++) begin
        r_cnt[k]  <= '0;
        r_bank[k] <= '0;
      end
      frame_done <= 1'b0;
    end else begin
      for (int k = 0; k < UNITS; k++) begin
        if (w_frame_end) begin
          r_bank[k] <= w_next[k];
          r_cnt[k]  <= '0;
        end else begin
          r_cnt[k]  <= w_next[k];
        end
      end
      frame_done <= w_frame_end;
    end
  end

  always_comb begin
    hist_count = '0;
    if (int'(hist_sel) < UNITS)
      hist_count = r_bank[hist_sel];
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_argmax_head.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_argmax_head
// Purpose  : Directed self-checking bench for seg_argmax_head on a 4x4 / 6x6 frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_argmax_head;

  localparam int FX    = 13;
  localparam int UNITS = 12;
  localparam int LB    = 4;
  localparam int VB    = 3;
  localparam int HB    = 3;
  localparam int CB    = 5;
  localparam int UB    = 8;

  logic              clock = 1'b0;
  logic              n_rst;
  logic [0:FX*UNITS-1] in_feat;
  logic [VB-1:0]     in_vcnt;
  logic [HB-1:0]     in_hcnt;
  logic [LB-1:0]     out_label;
  logic [UB-1:0]     out_conf;
  logic [VB-1:0]     out_vcnt;
  logic [HB-1:0]     out_hcnt;
  logic              frame_done;
  logic [LB-1:0]     hist_sel;
  logic [CB-1:0]     hist_count;

  int checks = 0;
  int errors = 0;

  seg_argmax_head #(
    .HEIGHT(4), .WIDTH(4), .W_HEIGHT(6), .W_WIDTH(6)
  ) dut (
    .clock(clock), .n_rst(n_rst), .in_feat(in_feat), .in_vcnt(in_vcnt), .in_hcnt(in_hcnt),
    .out_label(out_label), .out_conf(out_conf), .out_vcnt(out_vcnt), .out_hcnt(out_hcnt),
    .frame_done(frame_done), .hist_sel(hist_sel), .hist_count(hist_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [0:FX*UNITS-1] fill(input logic [FX-1:0] val);
    logic [0:FX*UNITS-1] f;
    for (int k = 0; k < UNITS; k++) f[k*FX +: FX] = val;
    return f;
  endfunction

  function automatic logic [0:FX*UNITS-1] label_feat(input int lab);
    logic [0:FX*UNITS-1] f;
    f = fill(13'h1F00);
    f[lab*FX +: FX] = 13'h0080;
    return f;
  endfunction

  // pat 0: active p<6 -> 1, p>=6 -> 5; pat 1: active -> 2; blanking -> 0
  function automatic int lab_of(input int pat, input int v, input int h);
    if (v >= 4 || h >= 4) return 0;
    if (pat == 1) return 2;
    return (v*4 + h >= 6) ? 5 : 1;
  endfunction

  function automatic int exp_bank(input int fr, input int sel);
    case (fr)
      0, 2:    return (sel == 1) ? 6 : (sel == 5) ? 10 : 0;
      1, 4:    return (sel == 2) ? 16 : 0;
      3:       return (sel == 5) ? 8 : 0;
      default: return 0;
    endcase
  endfunction

  logic [0:FX*UNITS-1] vecs [6];
  int elab [6] = '{7, 0, 3, 11, 2, 10};
  int econf[6] = '{8'h80, 8'h40, 8'hFF, 0, 8'hFF, 8'hFF};
  int ev   [6] = '{1, 2, 3, 4, 0, 5};
  int eh   [6] = '{2, 3, 4, 1, 5, 3};
  int sels [5] = '{0, 1, 2, 5, 12};
  int pat_of[6] = '{0, 1, 0, 0, 1, 0};

  initial begin
    n_rst    = 1'b0;
    in_feat  = '0;
    in_vcnt  = '0;
    in_hcnt  = '0;
    hist_sel = 4'd5;

    vecs[0] = label_feat(7);
    vecs[1] = fill(13'h0040);
    vecs[2] = fill(13'h0000);
    vecs[2][3*FX +: FX] = 13'h0100;
    vecs[2][9*FX +: FX] = 13'h0100;
    vecs[3] = fill(13'h1F00);
    vecs[3][11*FX +: FX] = 13'h1FFF;
    vecs[4] = fill(13'h1000);
    vecs[4][2*FX +: FX] = 13'h0FFF;
    vecs[5] = fill(13'h0000);
    vecs[5][10*FX +: FX] = 13'h00FF;
    vecs[5][11*FX +: FX] = 13'h00FF;

    repeat (2) @(negedge clock);
    chk("rst_label", out_label, 0);
    chk("rst_conf", out_conf, 0);
    chk("rst_vcnt", out_vcnt, 0);
    chk("rst_hcnt", out_hcnt, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_hist", hist_count, 0);
    n_rst = 1'b1;

    // Argmax / saturation vectors, checked exactly 5 cycles after entry
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      if (i >= 5) begin
        chk($sformatf("label%0d", i-5), out_label, elab[i-5]);
        chk($sformatf("conf%0d",  i-5), out_conf,  econf[i-5]);
        chk($sformatf("vcnt%0d",  i-5), out_vcnt,  ev[i-5]);
        chk($sformatf("hcnt%0d",  i-5), out_hcnt,  eh[i-5]);
      end
      if (i < 6) begin
        in_feat = vecs[i];
        in_vcnt = VB'(ev[i]);
        in_hcnt = HB'(eh[i]);
      end else begin
        in_feat = '0;
        in_vcnt = 3'd5;
        in_hcnt = 3'd0;
      end
    end

    @(negedge clock);
    n_rst = 1'b0;
    repeat (2) @(negedge clock);
    n_rst = 1'b1;

    // Frames: 0 A, 1 B, 2 A, 3 A with reset at pixels 8..10, 4 B, 5 partial flush
    for (int f = 0; f < 6; f++) begin
      for (int idx = 0; idx < 36; idx++) begin
        if (f == 5 && idx > 6) break;
        @(negedge clock);
        if (f == 3 && idx == 8)  n_rst = 1'b0;
        if (f == 3 && idx == 11) n_rst = 1'b1;
        #1;
        chk($sformatf("done_f%0d_p%0d", f, idx), frame_done, (f > 0 && idx == 5) ? 1 : 0);
        if (f == 3 && idx >= 8 && idx <= 10) begin
          chk("inrst_label", out_label, 0);
          chk("inrst_conf",  out_conf,  0);
          chk("inrst_vcnt",  out_vcnt,  0);
          chk("inrst_hcnt",  out_hcnt,  0);
        end
        if (f > 0 && idx == 5) begin
          for (int s = 0; s < 5; s++) begin
            hist_sel = LB'(sels[s]);
            #1;
            chk($sformatf("bank_f%0d_sel%0d", f-1, sels[s]), hist_count, exp_bank(f-1, sels[s]));
          end
        end
        in_vcnt = VB'(idx / 6);
        in_hcnt = HB'(idx % 6);
        in_feat = label_feat(lab_of(pat_of[f], idx / 6, idx % 6));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
